// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator with a registered,
// valid/ready output and a 2-entry (main + skid) buffer.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. The producer keeps inst/IMM_SRC/in_tag stable while in_valid=1 and
// in_ready=0. The consumer sees imm/err/out_tag held stable while out_valid=1
// and out_ready=0. in_ready is a flop driven from occupancy only, so it never
// combinationally depends on out_ready.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [2:0]       IMM_SRC,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic             err,
  output logic [TAG_W-1:0] out_tag
);

  // Occupancy states: EMPTY (0 entries), ONE (main only), TWO (main + skid).
  // The state register is the hook for occupancy checkers.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t state;

  // Immediate select encodings.
  localparam logic [2:0] SRC_I  = 3'b000;
  localparam logic [2:0] SRC_U  = 3'b001;
  localparam logic [2:0] SRC_S  = 3'b010;
  localparam logic [2:0] SRC_J  = 3'b011;
  localparam logic [2:0] SRC_B  = 3'b100;
  localparam logic [2:0] SRC_Z  = 3'b101;
  localparam logic [2:0] SRC_SH = 3'b110;

  // Extension result for the entry presented on the input this cycle.
  logic [XLEN-1:0]  new_imm;
  logic             new_err;

  // Skid register: holds the second entry while the consumer stalls.
  logic [XLEN-1:0]  skid_imm;
  logic             skid_err;
  logic [TAG_W-1:0] skid_tag;

  logic accept;

  // The opcode field never contributes to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^inst[6:0];

  assign accept = in_valid && in_ready;

  // Build the extended immediate from the instruction fields. Signed casts
  // replicate inst[31] up to XLEN; U only grows when XLEN exceeds 32.
  always_comb begin
    new_imm = '0;
    new_err = 1'b0;
    unique case (IMM_SRC)
      SRC_I:  new_imm = XLEN'($signed(inst[31:20]));
      SRC_U:  new_imm = XLEN'($signed({inst[31:12], 12'b0}));
      SRC_S:  new_imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      SRC_J:  new_imm = XLEN'($signed({inst[31], inst[19:12], inst[20],
                                        inst[30:21], 1'b0}));
      SRC_B:  new_imm = XLEN'($signed({inst[31], inst[7], inst[30:25],
                                        inst[11:8], 1'b0}));
      SRC_Z:  new_imm = XLEN'(inst[19:15]);
      SRC_SH: begin
        // RV64 shift amounts use one extra bit of the instruction.
        if (XLEN == 64) new_imm = XLEN'(inst[25:20]);
        else            new_imm = XLEN'(inst[24:20]);
      end
      default: begin
        new_imm = '0;
        new_err = 1'b1;
      end
    endcase
  end

  // Occupancy FSM with registered outputs: main register, skid register,
  // out_valid and in_ready all update together. Flush beats a same-edge accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      imm       <= '0;
      err       <= 1'b0;
      out_tag   <= '0;
      skid_imm  <= '0;
      skid_err  <= 1'b0;
      skid_tag  <= '0;
    end else if (flush) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            imm       <= new_imm;
            err       <= new_err;
            out_tag   <= in_tag;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && out_ready) begin
            // Current entry leaves as the new one arrives: reload main.
            imm     <= new_imm;
            err     <= new_err;
            out_tag <= in_tag;
          end else if (accept) begin
            // Consumer stalled: park the new entry behind main.
            skid_imm <= new_imm;
            skid_err <= new_err;
            skid_tag <= in_tag;
            in_ready <= 1'b0;
            state    <= ST_TWO;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_ready) begin
            imm      <= skid_imm;
            err      <= skid_err;
            out_tag  <= skid_tag;
            in_ready <= 1'b1;
            state    <= ST_ONE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance share all
// inputs. Directed vector table, hand-written stall/flush/reset sequences,
// then randomized traffic against a queue-based reference model.
module tb_imm_gen_pipe;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      inst = '0;
  logic [2:0]       imm_src = '0;
  logic [TAG_W-1:0] in_tag = '0;

  logic             in_ready32, out_valid32, err32;
  logic [31:0]      imm32;
  logic [TAG_W-1:0] out_tag32;
  logic             in_ready64, out_valid64, err64;
  logic [63:0]      imm64;
  logic [TAG_W-1:0] out_tag64;

  int n_cmp = 0;
  int n_bad = 0;

  // Clock / reset block.
  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready32), .inst(inst), .IMM_SRC(imm_src), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .imm(imm32),
    .err(err32), .out_tag(out_tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready64), .inst(inst), .IMM_SRC(imm_src), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .imm(imm64),
    .err(err64), .out_tag(out_tag64)
  );

  // Scoreboard entry and expected queue.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [63:0]      i32;
    logic [63:0]      i64;
    logic             e;
  } ent_t;
  ent_t exp_q[$];

  typedef struct {
    logic [2:0]       src;
    logic [31:0]      inst;
    logic [TAG_W-1:0] tag;
    logic [31:0]      e32;
    logic [63:0]      e64;
    logic             e_err;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference immediate from field arithmetic: unsigned field value, minus
  // 2^width when the sign bit is set, then truncated to xlen.
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] src,
                                          input int xlen);
    longint v;
    case (src)
      3'd0: begin v = w >> 20; if (w[31]) v -= 4096; end
      3'd1: begin v = w & 32'hFFFF_F000; if (w[31]) v -= 64'sh1_0000_0000; end
      3'd2: begin v = (w >> 25) * 32 + ((w >> 7) & 31); if (w[31]) v -= 4096; end
      3'd3: begin
        v = (((w >> 31) & 1) << 20) + (((w >> 12) & 255) << 12)
          + (((w >> 20) & 1) << 11) + (((w >> 21) & 1023) << 1);
        if (w[31]) v -= 2097152;
      end
      3'd4: begin
        v = (((w >> 31) & 1) << 12) + (((w >> 7) & 1) << 11)
          + (((w >> 25) & 63) << 5) + (((w >> 8) & 15) << 1);
        if (w[31]) v -= 8192;
      end
      3'd5: v = (w >> 15) & 31;
      3'd6: v = (w >> 20) & ((xlen == 64) ? 63 : 31);
      default: v = 0;
    endcase
    if (xlen == 32) return {32'b0, v[31:0]};
    return v;
  endfunction

  // Driver tasks.
  task automatic drive(input logic [2:0] src, input logic [31:0] w, input logic [TAG_W-1:0] t);
    in_valid = 1'b1;
    imm_src  = src;
    inst     = w;
    in_tag   = t;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Compare every output of both instances against the model.
  task automatic check_model();
    bit v;
    v = (exp_q.size() > 0);
    chk("rnd_valid32", out_valid32, v);
    chk("rnd_valid64", out_valid64, v);
    chk("rnd_ready32", in_ready32, exp_q.size() < 2);
    chk("rnd_ready64", in_ready64, exp_q.size() < 2);
    if (v) begin
      chk("rnd_tag32", out_tag32, exp_q[0].tag);
      chk("rnd_tag64", out_tag64, exp_q[0].tag);
      chk("rnd_imm32", imm32, exp_q[0].i32);
      chk("rnd_imm64", imm64, exp_q[0].i64);
      chk("rnd_err32", err32, exp_q[0].e);
      chk("rnd_err64", err64, exp_q[0].e);
    end
  endtask

  // Advance the model across one edge using the inputs driven for it.
  task automatic model_step();
    bit   acc;
    ent_t e;
    acc = in_valid && (exp_q.size() < 2);
    if (flush) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      if (acc) begin
        e.tag = in_tag;
        e.i32 = ref_imm(inst, imm_src, 32);
        e.i64 = ref_imm(inst, imm_src, 64);
        e.e   = (imm_src == 3'b111);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_entry(input string name, input logic [TAG_W-1:0] t,
                             input logic [31:0] e32, input logic [63:0] e64, input logic ee);
    chk({name, "_valid"}, out_valid32 & out_valid64, 1'b1);
    chk({name, "_tag"}, {out_tag64, out_tag32}, {t, t});
    chk({name, "_imm32"}, imm32, e32);
    chk({name, "_imm64"}, imm64, e64);
    chk({name, "_err"}, {err64, err32}, {ee, ee});
  endtask

  int seen;

  initial begin
    vecs[0]  = '{3'd0, 32'hFFF0_0093, 8'h01, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[1]  = '{3'd1, 32'h1234_5037, 8'h02, 32'h1234_5000, 64'h0000_0000_1234_5000, 1'b0};
    vecs[2]  = '{3'd2, 32'hFE11_2E23, 8'h03, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vecs[3]  = '{3'd3, 32'hFF9F_F06F, 8'h04, 32'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0};
    vecs[4]  = '{3'd5, 32'h000F_8073, 8'h05, 32'h0000_001F, 64'h0000_0000_0000_001F, 1'b0};
    vecs[5]  = '{3'd6, 32'h01F0_0013, 8'h06, 32'h0000_001F, 64'h0000_0000_0000_001F, 1'b0};
    vecs[6]  = '{3'd6, 32'h03F0_0013, 8'h07, 32'h0000_001F, 64'h0000_0000_0000_003F, 1'b0};
    vecs[7]  = '{3'd7, 32'hFFFF_FFFF, 8'h08, 32'h0000_0000, 64'h0000_0000_0000_0000, 1'b1};
    vecs[8]  = '{3'd1, 32'h8000_0037, 8'h09, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[9]  = '{3'd4, 32'hFE00_0EE3, 8'h0A, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vecs[10] = '{3'd0, 32'h7FF0_0093, 8'h0B, 32'h0000_07FF, 64'h0000_0000_0000_07FF, 1'b0};
    vecs[11] = '{3'd3, 32'h0080_006F, 8'h0C, 32'h0000_0008, 64'h0000_0000_0000_0008, 1'b0};
    vecs[12] = '{3'd5, 32'hFFF0_7FFF, 8'h0D, 32'h0000_0000, 64'h0000_0000_0000_0000, 1'b0};

    // Reset and reset-state checks.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_valid", {out_valid64, out_valid32}, 2'b00);
    chk("rst_ready", {in_ready64, in_ready32}, 2'b11);
    chk("rst_imm32", imm32, 64'h0);
    chk("rst_imm64", imm64, 64'h0);
    chk("rst_err_tag", {err64, err32, out_tag64, out_tag32}, '0);
    @(negedge clk);

    // Table-driven vectors, back-to-back with out_ready=1.
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].src, vecs[i].inst, vecs[i].tag);
      tick();
      check_entry($sformatf("vec%0d", i), vecs[i].tag, vecs[i].e32, vecs[i].e64, vecs[i].e_err);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {out_valid64, out_valid32}, 2'b00);

    // Backpressure: tags 1,2,3 pushed while the consumer stalls.
    out_ready = 1'b0;
    drive(3'd0, 32'hFFF0_0093, 8'd1);
    tick();
    check_entry("bp_t1a", 8'd1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    chk("bp_ready_one", {in_ready64, in_ready32}, 2'b11);
    drive(3'd1, 32'h1234_5037, 8'd2);
    tick();
    chk("bp_ready_two", {in_ready64, in_ready32}, 2'b00);
    check_entry("bp_t1b", 8'd1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    drive(3'd2, 32'hFE11_2E23, 8'd3);
    tick();
    chk("bp_ready_hold", {in_ready64, in_ready32}, 2'b00);
    check_entry("bp_t1c", 8'd1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    tick();
    check_entry("bp_t1d", 8'd1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    out_ready = 1'b1;
    tick();
    check_entry("bp_t2", 8'd2, 32'h1234_5000, 64'h0000_0000_1234_5000, 1'b0);
    chk("bp_ready_back", {in_ready64, in_ready32}, 2'b11);
    tick();
    check_entry("bp_t3", 8'd3, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", {out_valid64, out_valid32}, 2'b00);

    // Flush at occupancy 2 with a simultaneous in_valid.
    out_ready = 1'b0;
    drive(3'd0, 32'h0010_0093, 8'h10);
    tick();
    drive(3'd0, 32'h0020_0093, 8'h11);
    tick();
    drive(3'd0, 32'h0030_0093, 8'h12);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", {out_valid64, out_valid32}, 2'b00);
    chk("fl_ready", {in_ready64, in_ready32}, 2'b11);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (out_valid32 || out_valid64) seen++;
    end
    chk("fl_no_emerge", seen, 0);

    // Asynchronous reset between edges with occupancy 2.
    out_ready = 1'b0;
    drive(3'd1, 32'h1234_5037, 8'hA1);
    tick();
    drive(3'd7, 32'h0000_0000, 8'hA2);
    tick();
    in_valid = 1'b0;
    chk("ar_pre_ready", {in_ready64, in_ready32}, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {out_valid64, out_valid32}, 2'b00);
    chk("ar_imm32", imm32, 64'h0);
    chk("ar_imm64", imm64, 64'h0);
    chk("ar_err_tag", {err64, err32, out_tag64, out_tag32}, '0);
    chk("ar_ready", {in_ready64, in_ready32}, 2'b11);
    #1 rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    drive(3'd2, 32'hFE11_2E23, 8'h55);
    tick();
    check_entry("ar_first", 8'h55, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("ar_after_drain", {out_valid64, out_valid32}, 2'b00);

    // Randomized traffic against the reference model (starts empty).
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      check_model();
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = $urandom_range(0, 1);
      inst      = $urandom;
      imm_src   = 3'($urandom_range(0, 7));
      in_tag    = TAG_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    check_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, handshaked immediate generator for the decode stage. It accepts an instruction word, an immediate-type select and a tag. It produces the extended immediate at width XLEN, one cycle later, with a valid/ready interface. A 2-entry skid buffer decouples in_ready from out_ready. It adds CSR-uimm and shift-amount modes, an illegal-select error flag, XLEN=64 support and a synchronous flush.

Parameters:
XLEN, 32, immediate output width; legal values 32 or 64.
TAG_W, 8, width of the sideband tag (instruction ID) carried alongside each immediate.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous pipeline flush; discards all buffered entries.
in_valid  input  1  inst/IMM_SRC/in_tag are valid this cycle.
in_ready  output  1  block can accept an input this cycle.
inst  input  32  instruction word.
IMM_SRC  input  3  immediate type select.
in_tag  input  TAG_W  tag travelling with the instruction.
out_valid  output  1  imm/err/out_tag are valid.
out_ready  input  1  consumer accepts the output this cycle.
imm  output  XLEN  extended immediate.
err  output  1  IMM_SRC was 3'b111 for this entry.
out_tag  output  TAG_W  tag of the presented entry.

Behaviour:
- Immediate formats (s = inst[31], sign-replicated to XLEN):
  - 000 I: s-ext inst[31:20].
  - 001 U: s-ext {inst[31:12],12'b0}; this sign-extends only when XLEN=64.
  - 010 S: s-ext {inst[31:25],inst[11:7]}.
  - 011 J: s-ext {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
  - 100 B: s-ext {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}.
  - 101 Z: zero-ext inst[19:15] (CSR uimm).
  - 110 SH: zero-ext inst[24:20] when XLEN=32; zero-ext inst[25:20] when XLEN=64.
  - 111: imm=0, err=1.
  - err=0 for every other select.
- Extension is computed combinationally from the input and registered on acceptance. The output is always registered.
- Storage: output register (main) plus one skid register. Occupancy is 0, 1 or 2.
- States and transitions:
  - EMPTY: out_valid=0, in_ready=1. Accept (in_valid) → ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept with out_ready=1: main reloads with the new entry, stays ONE.
    - Accept with out_ready=0: the new entry goes to skid → TWO.
    - No accept with out_ready=1: → EMPTY.
    - Otherwise hold.
  - TWO: out_valid=1, in_ready=0.
    - out_ready=1: skid moves to main → ONE.
    - Otherwise hold.
- in_ready is a registered function of occupancy only and never depends combinationally on out_ready.
- Latency: an input accepted at edge N with the block EMPTY (or ONE with out_ready=1) presents at out_valid after edge N.
- Ordering: strict FIFO. Entries are never dropped or duplicated except by flush.
- Output stability: while out_valid=1 and out_ready=0, imm, err and out_tag hold their values.
- flush=1 at an edge: occupancy becomes 0 and out_valid becomes 0 on that edge. A simultaneous in_valid is dropped (flush wins). in_ready is 1 the next cycle.
- Reset (async, rst_n=0): out_valid=0, imm=0, err=0, out_tag=0, skid cleared, in_ready=1.
  - Reset asserted mid-transfer discards all entries immediately, without waiting for a clock.
  - Release is clean; the first accept may occur on the first edge after release.
- in_valid with in_ready=0: input ignored. The producer must hold it; the block does not register it.

Test Plan:
- XLEN=32, out_ready=1:
  - I 0xFFF00093 → imm 0xFFFFFFFF, one cycle later.
  - U 0x12345037 → 0x12345000.
  - S 0xFE112E23 → 0xFFFFFFFC.
  - J 0xFF9FF06F → 0xFFFFFFF8.
  - All with err=0 and tags matching.
- Z with inst[19:15]=5'h1F → 0x0000001F. SH with inst[24:20]=5'd31 → 0x1F. IMM_SRC=111 → imm 0, err=1.
- Backpressure: out_ready=0; push tags 1,2,3 back-to-back.
  - Tags 1 and 2 are accepted; in_ready=0 from the cycle after tag 2; tag 3 is held by the producer.
  - Raise out_ready: outputs appear as tags 1,2,3 on consecutive cycles, with imm stable while stalled.
- Flush with occupancy 2 and in_valid=1 on the same edge → out_valid=0 next cycle, in_ready=1, no entry ever emerges.
- XLEN=64:
  - I 0xFFF00093 → 0xFFFFFFFFFFFFFFFF.
  - U 0x80000037 → 0xFFFFFFFF80000000.
  - SH with inst[25:20]=6'd63 → 0x3F.
- Assert rst_n=0 between edges with occupancy 2 → out_valid, imm, err and out_tag go to 0 immediately. After release, a single accept produces correct output after one edge.
